// File: rtl/stopwatch_pkg.sv
// Shared state encoding and output decode for the stopwatch controller.
// Encoding 2'd3 is unused and treated as a recoverable illegal state.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    typedef struct packed {
        logic start;
        logic pause;
    } run_ctl_t;

    function automatic run_ctl_t decode_state(input state_t s);
        run_ctl_t ctl;
        ctl = '{start: 1'b0, pause: 1'b0};
        case (s)
            RUN:     ctl = '{start: 1'b1, pause: 1'b0};
            HOLD:    ctl = '{start: 1'b1, pause: 1'b1};
            default: ctl = '{start: 1'b0, pause: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on the debounced rising edge only.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync_2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear controller for a stopwatch counter, driven by two
// debounced pushbuttons; state is exported on state_o for LEDs and debug.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_go,
    input  logic       btn_clr,
    output logic       start,
    output logic       pause,
    output logic       clear,
    output logic [1:0] state_o
);

    state_t   state;
    state_t   state_next;
    run_ctl_t ctl_next;
    logic     go_ev;
    logic     clr_ev;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_go_btn (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_go),
        .press(go_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clr_btn (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_clr),
        .press(clr_ev)
    );

    // Clear overrides any simultaneous go event.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go_ev) state_next = RUN;
            RUN:     if (go_ev) state_next = HOLD;
            HOLD:    if (go_ev) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (clr_ev) state_next = IDLE;
        ctl_next = decode_state(state_next);
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
            pause <= 1'b0;
            clear <= 1'b0;
        end else begin
            state <= state_next;
            start <= ctl_next.start;
            pause <= ctl_next.pause;
            clear <= clr_ev;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a window-based behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_go = 1'b0;
    logic       btn_clr = 1'b0;
    logic       start;
    logic       pause;
    logic       clear;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    bit force_flag = 1'b0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_go (btn_go),
        .btn_clr(btn_clr),
        .start  (start),
        .pause  (pause),
        .clear  (clear),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Model: a raw level is accepted once the D synchronized samples that
    // precede an edge all differ from the current level; events follow two
    // edges later at the state register.
    logic [D+1:0] h_go = '0;
    logic [D+1:0] h_clr = '0;
    logic         m_lvl_go = 1'b0, m_lvl_clr = 1'b0;
    logic         m_rose_go = 1'b0, m_rose_clr = 1'b0;
    logic         m_ev_go = 1'b0, m_ev_clr = 1'b0;
    logic [1:0]   m_state = 2'd0;
    logic [1:0]   m_cur;
    logic [1:0]   m_nxt;
    logic         m_start = 1'b0, m_pause = 1'b0, m_clear = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            h_go = '0; h_clr = '0;
            m_lvl_go = 1'b0; m_lvl_clr = 1'b0;
            m_rose_go = 1'b0; m_rose_clr = 1'b0;
            m_ev_go = 1'b0; m_ev_clr = 1'b0;
            m_state = 2'd0; m_start = 1'b0; m_pause = 1'b0; m_clear = 1'b0;
        end else begin
            m_cur = force_flag ? 2'd3 : m_state;
            if (m_ev_clr)          m_nxt = 2'd0;
            else if (m_cur == 2'd3) m_nxt = 2'd0;
            else if (m_ev_go)      m_nxt = (m_cur == 2'd1) ? 2'd2 : 2'd1;
            else                   m_nxt = m_cur;
            m_state = m_nxt;
            m_start = (m_nxt != 2'd0);
            m_pause = (m_nxt == 2'd2);
            m_clear = m_ev_clr;
            m_ev_go  = m_rose_go;
            m_ev_clr = m_rose_clr;
            h_go  = {h_go[D:0], btn_go};
            h_clr = {h_clr[D:0], btn_clr};
            m_rose_go  = 1'b0;
            m_rose_clr = 1'b0;
            if (h_go[D+1:2] == {D{~m_lvl_go}}) begin
                m_rose_go = ~m_lvl_go;
                m_lvl_go  = ~m_lvl_go;
            end
            if (h_clr[D+1:2] == {D{~m_lvl_clr}}) begin
                m_rose_clr = ~m_lvl_clr;
                m_lvl_clr  = ~m_lvl_clr;
            end
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !reset) begin
            check("model_state", state_o, m_state);
            check("model_start", {1'b0, start}, {1'b0, m_start});
            check("model_pause", {1'b0, pause}, {1'b0, m_pause});
            check("model_clear", {1'b0, clear}, {1'b0, m_clear});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press_go();
        btn_go = 1'b1;
        tick(10);
        btn_go = 1'b0;
        tick(10);
    endtask

    task automatic check_outs(input string name, input logic [1:0] st, input logic s, input logic p);
        check({name, "_state"}, state_o, st);
        check({name, "_start"}, {1'b0, start}, {1'b0, s});
        check({name, "_pause"}, {1'b0, pause}, {1'b0, p});
    endtask

    initial begin
        tick(2);
        check_outs("reset", 2'd0, 1'b0, 1'b0);
        check("reset_clear", {1'b0, clear}, 2'd0);
        reset = 1'b0;
        check_en = 1'b1;

        // Bounce: 3 high, 1 low, 3 high is never stable for D samples.
        btn_go = 1'b1; tick(3);
        btn_go = 1'b0; tick(1);
        btn_go = 1'b1; tick(3);
        btn_go = 1'b0; tick(20);
        check_outs("bounce", 2'd0, 1'b0, 1'b0);

        // Clean press: output changes D+4 = 8 clocks after the press edge.
        pulse_reset();
        btn_go = 1'b1;
        tick(7);
        check_outs("latency_early", 2'd0, 1'b0, 1'b0);
        tick(1);
        check_outs("latency_edge", 2'd1, 1'b1, 1'b0);
        tick(11);
        btn_go = 1'b0;
        tick(10);
        check_outs("single_event", 2'd1, 1'b1, 1'b0);

        // go, go, go from IDLE.
        pulse_reset();
        press_go();
        check_outs("seq1", 2'd1, 1'b1, 1'b0);
        press_go();
        check_outs("seq2", 2'd2, 1'b1, 1'b1);
        press_go();
        check_outs("seq3", 2'd1, 1'b1, 1'b0);

        // Simultaneous go and clr in RUN: clr wins.
        btn_go = 1'b1; btn_clr = 1'b1;
        tick(7);
        check_outs("both_before", 2'd1, 1'b1, 1'b0);
        tick(1);
        check_outs("both_after", 2'd0, 1'b0, 1'b0);
        check("both_clear_on", {1'b0, clear}, 2'd1);
        tick(1);
        check("both_clear_off", {1'b0, clear}, 2'd0);
        check("both_no_hold", state_o, 2'd0);
        btn_go = 1'b0; btn_clr = 1'b0;
        tick(12);
        check("both_settled", state_o, 2'd0);

        // Asynchronous reset in HOLD with a go debounce in flight.
        press_go();
        press_go();
        check_outs("hold_entry", 2'd2, 1'b1, 1'b1);
        btn_go = 1'b1;
        tick(4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_outs("async_reset", 2'd0, 1'b0, 1'b0);
        check("async_reset_clear", {1'b0, clear}, 2'd0);
        @(negedge clk);
        btn_go = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        check_outs("post_reset_quiet", 2'd0, 1'b0, 1'b0);

        // Button already held when reset releases produces one event.
        reset = 1'b1;
        btn_go = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(D + 6);
        check_outs("held_thru_reset", 2'd1, 1'b1, 1'b0);
        btn_go = 1'b0;
        tick(10);
        check("held_one_event", state_o, 2'd1);

        // Illegal encoding recovers to IDLE on the next clock.
        check_en = 1'b0;
        force dut.state = state_t'(ST_ILLEGAL);
        #1 release dut.state;
        force_flag = 1'b1;
        check("illegal_forced", state_o, ST_ILLEGAL);
        @(posedge clk);
        #1 force_flag = 1'b0;
        check_outs("illegal_recover", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_en = 1'b1;
        tick(5);
        check("illegal_stays_idle", state_o, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable synchronized samples needed to accept a button level change; legal range 2..2^24-1.
REQ-002 Parameter CNT_W, default 24, SHALL set the debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_W bits.
REQ-003 Port clk, input, 1 bit: single system clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 Port btn_go, input, 1 bit: raw asynchronous start/pause pushbutton, high when pressed.
REQ-006 Port btn_clr, input, 1 bit: raw asynchronous clear pushbutton, high when pressed.
REQ-007 Port start, output, 1 bit: run enable to the downstream stopwatch counter.
REQ-008 Port pause, output, 1 bit: hold request to the downstream counter.
REQ-009 Port clear, output, 1 bit: one-cycle pulse that drives the counter's reset input.
REQ-010 Port state_o, output, 2 bits: current FSM state, for LEDs and debug.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounce counter: clear to 0 whenever the synchronized sample equals the debounced level, otherwise increment; when the counter equals DEBOUNCE_CYCLES-1 while the sample still differs, the debounced level SHALL take the sample and the counter SHALL clear.
REQ-013 A bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change.
REQ-014 A press event SHALL be a registered one-cycle pulse, high in the cycle after the debounced level rises; the release edge SHALL generate no event.
REQ-015 A held button SHALL generate exactly one event, whatever the hold duration.
REQ-016 FSM states SHALL be IDLE=2'd0, RUN=2'd1, HOLD=2'd2; encoding 2'd3 is illegal and SHALL recover to IDLE on the next clock.
REQ-017 go event transitions: IDLE->RUN, RUN->HOLD, HOLD->RUN.
REQ-018 A clr event SHALL move any state to IDLE and assert clear for exactly one cycle, registered and coincident with the state change.
REQ-019 If go and clr events occur in the same cycle, clr SHALL win: next state IDLE, clear=1, go discarded.
REQ-020 Outputs SHALL be registered and decoded from state: IDLE start=0 pause=0; RUN start=1 pause=0; HOLD start=1 pause=1.
REQ-021 Latency from a clean raw press edge to the output change SHALL be DEBOUNCE_CYCLES+4 clocks: 2 synchronizer, DEBOUNCE_CYCLES debounce, 1 pulse, 1 state.

Reset
REQ-022 While reset is high, all flops SHALL asynchronously clear: synchronizers 0, debounced levels 0, counters 0, state IDLE, start=0, pause=0, clear=0, state_o=0.
REQ-023 After reset deasserts with a button already held, that press SHALL be debounced normally and produce one event.
REQ-024 Reset asserted mid-debounce SHALL discard any partial count, and no event SHALL follow deassertion unless the button is stably pressed.

Structure
REQ-025 State encodings and the IDLE/RUN/HOLD constants SHALL reside in shared package stopwatch_pkg.
REQ-026 Synchronizer, debounce counter and press-pulse logic SHALL form sub-module btn_debounce, instantiated once per button; the FSM stays in stopwatch_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, then a clean btn_go press held 20 cycles -> start=1 and pause=0 exactly 8 clocks after the press edge, and only one transition occurs.
REQ-028 btn_go pulses 3 cycles high, 1 low, 3 high, then stays low -> no event; state_o remains 0.
REQ-029 Sequence go, go, go with release and 10 idle cycles between presses -> states RUN, HOLD, RUN; (start,pause) = (1,0), (1,1), (1,0).
REQ-030 In RUN, btn_go and btn_clr pressed on the same edge -> state IDLE, clear high exactly 1 cycle, start=0, no RUN->HOLD transition.
REQ-031 Assert reset asynchronously between clock edges while in HOLD with a debounce in progress -> outputs 0 immediately; after release with buttons low for 20 cycles, no event.
REQ-032 Force state to 2'd3 -> state_o=0 and outputs at IDLE values on the next clock.
